// File: rtl/if_id_stage_pkg.sv
// Shared fetch-pipeline constants and types for the IF stage and IF/ID register.
package if_id_stage_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter with next-PC selection: reset, hold, redirect, or sequential step.
module pc_reg
    import if_id_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pc_write_i,
    input  logic              pc_src_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Sequential step wraps naturally modulo 2^32.
    assign pc_plus4_o = pc_q + PC_STEP;
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (pc_write_i) begin
            if (pc_src_i) pc_d = word_align(branch_target_i);
            else          pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pc_q <= word_align(RESET_PC);
        else       pc_q <= pc_d;
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and stall counter.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned       STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PC_Write,
    input  logic                   IF_ID_Write,
    input  logic                   PCSrc,
    input  logic [ADDR_W-1:0]      branch_target,
    input  logic                   IF_Flush,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]     imem_data,
    output logic [ADDR_W-1:0]      IF_ID_PC4,
    output logic [INSTR_W-1:0]     IF_ID_Instr,
    output logic                   IF_ID_Valid,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [ADDR_W-1:0]      pc_plus4;
    if_id_t                 ifid_q;
    if_id_t                 ifid_d;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_d;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_write_i      (PC_Write),
        .pc_src_i        (PCSrc),
        .branch_target_i (branch_target),
        .pc_o            (imem_addr),
        .pc_plus4_o      (pc_plus4)
    );

    // A flush bubble still records PC+4; only reset clears it.
    always_comb begin
        ifid_d = ifid_q;
        if (IF_ID_Write) begin
            ifid_d.pc4 = pc_plus4;
            if (IF_Flush) begin
                ifid_d.instr = NOP_INSTR;
                ifid_d.valid = 1'b0;
            end else begin
                ifid_d.instr = imem_data;
                ifid_d.valid = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!PC_Write && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q.pc4   <= '0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
            stall_q      <= '0;
        end else begin
            ifid_q  <= ifid_d;
            stall_q <= stall_d;
        end
    end

    assign IF_ID_PC4   = ifid_q.pc4;
    assign IF_ID_Instr = ifid_q.instr;
    assign IF_ID_Valid = ifid_q.valid;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus random traffic against a reference model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PC_Write = 1'b1;
    logic        IF_ID_Write = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] branch_target = '0;
    logic        IF_Flush = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic [15:0] stall_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model state
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;
    int unsigned m_stall;

    if_id_stage #(
        .RESET_PC    (32'h0000_0000),
        .STALL_CNT_W (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_Write      (PC_Write),
        .IF_ID_Write   (IF_ID_Write),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .IF_Flush      (IF_Flush),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .IF_ID_PC4     (IF_ID_PC4),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_Valid   (IF_ID_Valid),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr,            m_pc);
        check({tag, ".pc4"},   IF_ID_PC4,            m_pc4);
        check({tag, ".instr"}, IF_ID_Instr,          m_instr);
        check({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, m_valid});
        check({tag, ".stall"}, {16'd0, stall_count}, m_stall);
    endtask

    // One clock: drive inputs, advance the model by the stated rules, compare after the edge.
    task automatic step(input string tag, input logic r, input logic pcw, input logic idw,
                        input logic src, input logic [31:0] tgt, input logic fl,
                        input logic [31:0] data, input bit do_check);
        rst = r; PC_Write = pcw; IF_ID_Write = idw; PCSrc = src;
        branch_target = tgt; IF_Flush = fl; imem_data = data;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_stall = 0;
        end else begin
            if (idw) begin
                m_pc4   = m_pc + 32'd4;
                m_instr = fl ? 32'h0 : data;
                m_valid = !fl;
            end
            if (!pcw) begin
                if (m_stall < 65535) m_stall++;
            end else if (src) begin
                m_pc = (tgt / 4) * 4;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        if (do_check) check_all(tag);
    endtask

    localparam logic [31:0] LW = 32'h8C08_0004;

    initial begin
        m_pc = '0; m_pc4 = '0; m_instr = '0; m_valid = 1'b0; m_stall = 0;

        // reset and free run
        step("reset", 1, 1, 1, 1, 32'h40, 1, 32'hDEAD_BEEF, 1);
        check("reset.pc0", imem_addr, 32'h0);
        step("run1", 0, 1, 1, 0, 0, 0, LW, 1);
        check("run1.pc4", IF_ID_PC4, 32'h4);
        check("run1.valid", {31'd0, IF_ID_Valid}, 32'd1);
        check("run1.instr", IF_ID_Instr, LW);
        step("run2", 0, 1, 1, 0, 0, 0, LW, 1);
        check("run2.addr", imem_addr, 32'h8);

        // two-cycle load-use stall at PC=8
        step("stall1", 0, 0, 0, 0, 0, 0, 32'h1111_1111, 1);
        step("stall2", 0, 0, 0, 0, 0, 0, 32'h2222_2222, 1);
        check("stall.addr", imem_addr, 32'h8);
        check("stall.cnt", {16'd0, stall_count}, 32'd2);
        check("stall.pc4", IF_ID_PC4, 32'h8);
        step("run3", 0, 1, 1, 0, 0, 0, LW, 1);
        check("run3.addr", imem_addr, 32'hC);

        // redirect with flush, misaligned target
        step("redir", 0, 1, 1, 1, 32'h0000_0103, 1, LW, 1);
        check("redir.addr", imem_addr, 32'h100);
        check("redir.instr", IF_ID_Instr, 32'h0);
        check("redir.valid", {31'd0, IF_ID_Valid}, 32'd0);
        check("redir.pc4", IF_ID_PC4, 32'h10);

        // stall swallows redirect and flush
        step("lost_pre", 0, 1, 1, 0, 0, 0, 32'hA5A5_0001, 1);
        step("lost", 0, 0, 0, 1, 32'h0000_0800, 1, 32'hA5A5_0002, 1);
        check("lost.addr", imem_addr, 32'h104);
        check("lost.valid", {31'd0, IF_ID_Valid}, 32'd1);

        // wrap at top of address space
        step("top", 0, 1, 1, 1, 32'hFFFF_FFFF, 0, 32'h1234_5678, 1);
        check("top.addr", imem_addr, 32'hFFFF_FFFC);
        step("wrap", 0, 1, 1, 0, 0, 0, 32'h0BAD_F00D, 1);
        check("wrap.addr", imem_addr, 32'h0);
        check("wrap.pc4", IF_ID_PC4, 32'h0);
        check("wrap.valid", {31'd0, IF_ID_Valid}, 32'd1);

        // randomized traffic including occasional reset
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), $urandom,
                 ($urandom_range(0, 4) == 0), $urandom, 1);
        end

        // saturation of the stall counter, then reset mid-stall
        step("sat_rst", 1, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65540; i++) begin
            step("sat", 0, 0, $urandom_range(0, 1), 1, $urandom, 1, $urandom, (i % 4096) == 0);
        end
        check_all("sat.end");
        check("sat.cnt", {16'd0, stall_count}, 32'h0000_FFFF);
        step("sat.clr", 1, 0, 1, 1, 32'h0000_0200, 1, LW, 1);
        check("sat.clr.cnt", {16'd0, stall_count}, 32'h0);
        check("sat.clr.addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of stall_count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port PC_Write  input  1  1 = PC may update; 0 = hold PC (load-use stall).
REQ-006 SHALL have port IF_ID_Write  input  1  1 = IF/ID register may load; 0 = hold.
REQ-007 SHALL have port PCSrc  input  1  taken branch/jump resolved in ID.
REQ-008 SHALL have port branch_target  input  32  redirect address for PCSrc.
REQ-009 SHALL have port IF_Flush  input  1  replace the fetched instruction with a bubble.
REQ-010 SHALL have port imem_addr  output  32  current PC to instruction memory.
REQ-011 SHALL have port imem_data  input  32  instruction at imem_addr, combinational read, same cycle.
REQ-012 SHALL have port IF_ID_PC4  output  32  registered PC+4 of the held instruction.
REQ-013 SHALL have port IF_ID_Instr  output  32  registered instruction.
REQ-014 SHALL have port IF_ID_Valid  output  1  1 = IF_ID_Instr is real, 0 = bubble.
REQ-015 SHALL have port stall_count  output  STALL_CNT_W  saturating count of cycles with PC_Write=0.

Function
REQ-016 imem_addr SHALL equal the PC register directly, with no added latency.
REQ-017 PC next-state priority SHALL be: rst -> RESET_PC; else PC_Write=0 -> hold (PCSrc ignored); else PCSrc=1 -> {branch_target[31:2],2'b00}; else PC+4.
REQ-018 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no error flag.
REQ-019 PC[1:0] SHALL always be 2'b00; branch_target[1:0] SHALL be ignored.
REQ-020 IF/ID next-state priority SHALL be: rst -> bubble; else IF_ID_Write=0 -> hold all three fields (IF_Flush ignored); else IF_Flush=1 -> bubble; else load {PC+4, imem_data, Valid=1}.
REQ-021 A bubble SHALL set IF_ID_Instr=32'h0000_0000 (nop) and IF_ID_Valid=0; IF_ID_PC4 SHALL still load PC+4 when the bubble comes from flush, and SHALL be 0 when it comes from reset.
REQ-022 Fetch-to-IF/ID latency SHALL be exactly 1 cycle; a redirect SHALL appear on imem_addr 1 cycle after PCSrc is sampled.
REQ-023 PC_Write and IF_ID_Write SHALL act independently; a mismatched pair SHALL apply each rule unchanged, with no checking.
REQ-024 stall_count SHALL increment by 1 in each non-reset cycle with PC_Write=0, and SHALL saturate at all-ones.
REQ-025 Simultaneous PCSrc=1 and IF_Flush=1 with both writes enabled SHALL redirect the PC and bubble IF/ID in the same edge.

Reset
REQ-026 On rst=1 at a rising edge: PC=RESET_PC, IF_ID_PC4=0, IF_ID_Instr=0, IF_ID_Valid=0, stall_count=0.
REQ-027 rst SHALL override all other inputs in the same cycle, including in mid-stall and mid-redirect.
REQ-028 The first fetch after reset release SHALL use RESET_PC, and IF_ID_Valid SHALL rise on the following edge.

Structure
REQ-029 A shared pipeline package SHALL hold the following: RESET_PC default, NOP_INSTR=32'h0, INSTR_W=32, ADDR_W=32, PC_STEP=4.
REQ-030 The PC register with its next-PC mux SHALL be one sub-module, pc_reg; the IF/ID register and stall counter SHALL stay in the top level.
REQ-031 No latches are permitted; every output SHALL be driven from a flop, except imem_addr, which is the flop output directly.

Verification
REQ-032 Reset then 3 free-run cycles, imem_data=32'h8C08_0004 -> imem_addr 0,4,8,12; IF_ID_PC4=4 with Valid=1 after the first edge.
REQ-033 Hold PC_Write=0 and IF_ID_Write=0 for 2 cycles at PC=8 -> imem_addr stays 8, IF/ID unchanged, stall_count 0->2.
REQ-034 PCSrc=1, branch_target=32'h0000_0103, IF_Flush=1 -> next imem_addr=32'h0000_0100; IF_ID_Instr=0, Valid=0.
REQ-035 PC_Write=0 together with PCSrc=1 and IF_Flush=1 (IF_ID_Write=0) -> PC, IF/ID and Valid all hold; redirect lost.
REQ-036 PC=32'hFFFF_FFFC, free run -> next imem_addr=0; IF_ID_PC4=0, Valid=1.
REQ-037 Force PC_Write=0 for 65540 cycles, then assert rst mid-stall -> stall_count saturates at 16'hFFFF and resets to 0 on the rst edge.
